// File: rtl/conv_mac_engine.sv
// Convolution MAC engine: multiply, adder tree and accumulate over LANES pairs per beat,
// then rescale, saturate, optional ReLU and pack PACK results per output word.
module conv_mac_engine #(
  parameter int LANES = 4,
  parameter int DW    = 16,
  parameter int ACC_W = 40,
  parameter int FRAC  = 8,
  parameter int PACK  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  input  logic                    in_eop,
  input  logic [LANES*DW-1:0]     ifm_data,
  input  logic [LANES*DW-1:0]     w_data,
  input  logic                    relu_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [PACK*DW-1:0]      out_data,
  output logic [$clog2(PACK+1)-1:0] out_cnt,
  output logic                    sat_flag,
  output logic                    busy
);
  localparam int KW = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int CW = $clog2(PACK + 1);
  localparam logic signed [ACC_W:0] HALF_C = $signed({{ACC_W{1'b0}}, 1'b1} << (FRAC - 1));
  localparam logic signed [ACC_W:0] MAX_C  = $signed({{(ACC_W + 2 - DW){1'b0}}, {(DW - 1){1'b1}}});
  localparam logic signed [ACC_W:0] MIN_C  = ~MAX_C;

  function automatic logic signed [2*DW-1:0] mul_f(input logic signed [DW-1:0] a,
                                                   input logic signed [DW-1:0] b);
    return (2*DW)'(a) * (2*DW)'(b);
  endfunction

  logic                       stall_s, accept_s, fire_s, emit_s, sat_s;
  logic                       s1_valid_r, s1_last_r, s1_eop_r, s1_relu_r;
  logic signed [2*DW-1:0]     s1_prod_r [LANES];
  logic                       s2_valid_r, s2_last_r, s2_eop_r, s2_relu_r;
  logic signed [ACC_W-1:0]    tree_sum_s, s2_sum_r, acc_r, acc_next_s;
  logic signed [ACC_W:0]      rnd_s, shr_s;
  logic        [DW-1:0]       clamp_s, res_s;
  logic        [KW-1:0]       k_r;
  logic        [PACK*DW-1:0]  pack_r, word_s, out_data_r;
  logic        [CW-1:0]       out_cnt_r;
  logic                       out_valid_r, sat_flag_r;

  assign stall_s   = out_valid_r && !out_ready;
  assign in_ready  = !stall_s;
  assign accept_s  = in_valid && !stall_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_cnt   = out_cnt_r;
  assign sat_flag  = sat_flag_r;
  assign busy      = s1_valid_r || s2_valid_r || (k_r != KW'(0));

  // S1: per-lane products; sideband only latched from accepted beats
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_last_r  <= 1'b0;
      s1_eop_r   <= 1'b0;
      s1_relu_r  <= 1'b0;
      for (int i = 0; i < LANES; i++) s1_prod_r[i] <= '0;
    end else if (!stall_s) begin
      s1_valid_r <= accept_s;
      s1_last_r  <= accept_s && in_last;
      s1_eop_r   <= accept_s && in_last && in_eop;
      s1_relu_r  <= accept_s && relu_en;
      for (int i = 0; i < LANES; i++)
        s1_prod_r[i] <= mul_f(ifm_data[(LANES-i)*DW-1 -: DW], w_data[(LANES-i)*DW-1 -: DW]);
    end
  end

  // Adder tree over sign-extended products
  always_comb begin
    tree_sum_s = '0;
    for (int i = 0; i < LANES; i++) tree_sum_s = tree_sum_s + ACC_W'(s1_prod_r[i]);
  end

  // S2: registered tree sum
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      s2_last_r  <= 1'b0;
      s2_eop_r   <= 1'b0;
      s2_relu_r  <= 1'b0;
      s2_sum_r   <= '0;
    end else if (!stall_s) begin
      s2_valid_r <= s1_valid_r;
      s2_last_r  <= s1_last_r;
      s2_eop_r   <= s1_eop_r;
      s2_relu_r  <= s1_relu_r;
      s2_sum_r   <= tree_sum_s;
    end
  end

  // S3 datapath: accumulate, round-half-up rescale, clamp, ReLU, slot insert
  always_comb begin
    fire_s     = !stall_s && s2_valid_r;
    acc_next_s = acc_r + s2_sum_r;
    rnd_s      = $signed({acc_next_s[ACC_W-1], acc_next_s}) + HALF_C;
    shr_s      = rnd_s >>> FRAC;
    sat_s      = 1'b0;
    if (shr_s > MAX_C) begin
      clamp_s = MAX_C[DW-1:0];
      sat_s   = 1'b1;
    end else if (shr_s < MIN_C) begin
      clamp_s = MIN_C[DW-1:0];
      sat_s   = 1'b1;
    end else begin
      clamp_s = shr_s[DW-1:0];
    end
    res_s  = (s2_relu_r && clamp_s[DW-1]) ? {DW{1'b0}} : clamp_s;
    word_s = pack_r;
    for (int j = 0; j < PACK; j++) begin
      if (KW'(j) == k_r) word_s[(PACK-j)*DW-1 -: DW] = res_s;
      else               word_s[(PACK-j)*DW-1 -: DW] = pack_r[(PACK-j)*DW-1 -: DW];
    end
    emit_s = fire_s && s2_last_r && ((k_r == KW'(PACK - 1)) || s2_eop_r);
  end

  // S3 state: accumulator, pack register, output word and sticky saturation
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_r       <= '0;
      k_r         <= '0;
      pack_r      <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_cnt_r   <= '0;
      sat_flag_r  <= 1'b0;
    end else begin
      if (fire_s) begin
        acc_r <= s2_last_r ? {ACC_W{1'b0}} : acc_next_s;
        if (s2_last_r) begin
          sat_flag_r <= sat_flag_r | sat_s;
          if (emit_s) begin
            k_r        <= '0;
            pack_r     <= '0;
            out_data_r <= word_s;
            out_cnt_r  <= CW'(k_r) + CW'(1);
          end else begin
            k_r    <= k_r + KW'(1);
            pack_r <= word_s;
          end
        end
      end
      // A consumed word may be replaced by a new one in the same cycle
      if (emit_s)         out_valid_r <= 1'b1;
      else if (out_ready) out_valid_r <= 1'b0;
    end
  end
endmodule

// File: tb/tb_conv_mac_engine.sv
// Self-checking bench for conv_mac_engine: directed scenarios plus randomized neurons
// compared against an arithmetic reference model of the engine's results.
module tb_conv_mac_engine;
  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_last = 1'b0, in_eop = 1'b0;
  logic        relu_en = 1'b0, out_ready = 1'b1;
  logic [63:0] ifm_data = 64'h0, w_data = 64'h0;
  logic        in_ready, out_valid, sat_flag, busy;
  logic [63:0] out_data;
  logic [2:0]  out_cnt;

  conv_mac_engine #(.LANES(4), .DW(16), .ACC_W(40), .FRAC(8), .PACK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_eop(in_eop), .ifm_data(ifm_data), .w_data(w_data), .relu_en(relu_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_cnt(out_cnt),
    .sat_flag(sat_flag), .busy(busy));

  always #5 clk = ~clk;

  typedef struct { logic [63:0] d; logic [2:0] c; int cy; } word_t;
  word_t       got[$], exp_q[$];
  int          n_vec = 0, n_fail = 0, cyc = 0, acc_cyc = 0;
  longint      m_acc = 0;
  logic [15:0] m_slots[$];
  logic        m_sat = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1)
      got.push_back('{out_data, out_cnt, cyc});

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  function automatic void model_reset();
    m_acc = 0; m_slots.delete(); exp_q.delete(); got.delete(); m_sat = 1'b0;
  endfunction

  // Reference: dot product, 40-bit wrapping accumulate, rounded rescale, clamp, ReLU, pack
  function automatic void model_beat(logic [63:0] f, logic [63:0] w, logic last, logic eop, logic relu);
    longint dot = 0, r;
    logic signed [15:0] a, b;
    word_t wd;
    for (int i = 0; i < 4; i++) begin
      a = f[63-16*i -: 16]; b = w[63-16*i -: 16];
      dot += longint'(a) * longint'(b);
    end
    m_acc = ((m_acc + dot) <<< 24) >>> 24;
    if (last) begin
      r = (m_acc + 128) >>> 8;
      if (r > 32767) begin r = 32767; m_sat = 1'b1; end
      else if (r < -32768) begin r = -32768; m_sat = 1'b1; end
      if (relu && r < 0) r = 0;
      m_slots.push_back(r[15:0]);
      m_acc = 0;
      if (m_slots.size() == 4 || eop) begin
        wd.d = 64'h0; wd.cy = 0; wd.c = 3'(m_slots.size());
        for (int i = 0; i < m_slots.size(); i++) wd.d[63-16*i -: 16] = m_slots[i];
        exp_q.push_back(wd);
        m_slots.delete();
      end
    end
  endfunction

  task automatic send_beat(input logic [63:0] f, input logic [63:0] w,
                           input logic last, input logic eop, input logic relu);
    int n = 0;
    in_valid = 1'b1; ifm_data = f; w_data = w; in_last = last; in_eop = eop; relu_en = relu;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL beat_accept: in_ready=%b want 1", in_ready);
    end
    @(posedge clk); #1;
    model_beat(f, w, last, eop, relu);
    acc_cyc = cyc;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; in_last = 1'b0; in_eop = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; ifm_data = rnd64(); w_data = rnd64(); in_last = 1'b1; in_eop = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec += 4;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    if (out_data !== 64'h0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL reset_sat_flag: got %b want 0", sat_flag); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_eop = 1'b0;
    model_reset();
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_beat();
    got.delete(); exp_q.delete();
    for (int i = 0; i < 4; i++) send_beat(64'h0100_0100_0100_0100, 64'h0200_0200_0200_0200, 1'b1, 1'b0, 1'b0);
    idle(6);
    n_vec++;
    if (got.size() != 1) begin n_fail++; $display("FAIL single_count: got %0d words want 1", got.size()); end
    if (got.size() >= 1) begin
      n_vec += 3;
      if (got[0].d !== 64'h0800_0800_0800_0800) begin
        n_fail++; $display("FAIL single_data: got %h want 0800080008000800", got[0].d);
      end
      if (got[0].c !== 3'd4) begin n_fail++; $display("FAIL single_cnt: got %0d want 4", got[0].c); end
      if (got[0].cy - acc_cyc != 2) begin
        n_fail++; $display("FAIL single_latency: got %0d edges want 2", got[0].cy - acc_cyc);
      end
    end
  endtask

  task automatic test_relu();
    logic [63:0] r64, f, w;
    got.delete(); exp_q.delete();
    r64 = rnd64(); f = {16'hFFFE, r64[47:0]}; w = {16'h0300, 48'h0};
    send_beat(f, w, 1'b0, 1'b1, 1'b0);
    send_beat(f, w, 1'b0, 1'b0, 1'b0);
    send_beat(f, w, 1'b1, 1'b0, 1'b1);
    send_beat(f, w, 1'b0, 1'b0, 1'b1);
    send_beat(f, w, 1'b0, 1'b0, 1'b1);
    send_beat(f, w, 1'b1, 1'b1, 1'b0);
    idle(6);
    n_vec++;
    if (got.size() != 1) begin n_fail++; $display("FAIL relu_count: got %0d words want 1", got.size()); end
    if (got.size() >= 1) begin
      n_vec += 2;
      if (got[0].d !== 64'h0000_FFEE_0000_0000) begin
        n_fail++; $display("FAIL relu_data: got %h want 0000ffee00000000", got[0].d);
      end
      if (got[0].c !== 3'd2) begin n_fail++; $display("FAIL relu_cnt: got %0d want 2", got[0].c); end
    end
  endtask

  task automatic test_saturation();
    got.delete(); exp_q.delete();
    n_vec++;
    if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL sat_before: got %b want 0", sat_flag); end
    send_beat(64'h7FFF_7FFF_7FFF_7FFF, 64'h7FFF_7FFF_7FFF_7FFF, 1'b1, 1'b1, 1'b0);
    idle(6);
    n_vec += 3;
    if (got.size() != 1) begin n_fail++; $display("FAIL sat_count: got %0d words want 1", got.size()); end
    else begin
      if (got[0].d !== 64'h7FFF_0000_0000_0000 || got[0].c !== 3'd1) begin
        n_fail++; $display("FAIL sat_word: got %h/%0d want 7fff000000000000/1", got[0].d, got[0].c);
      end
    end
    if (sat_flag !== 1'b1) begin n_fail++; $display("FAIL sat_flag: got %b want 1", sat_flag); end
    n_vec++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL sat_busy: got %b want 0", busy); end
  endtask

  task automatic test_backpressure();
    got.delete(); exp_q.delete();
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 12; i++) send_beat(rnd64(), rnd64(), 1'b1, 1'b0, 1'($urandom_range(0, 1)));
        idle(1);
      end
      begin
        int n = 0;
        logic [63:0] held;
        while (out_valid !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        n_vec++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_first_word: out_valid=%b want 1", out_valid); end
        held = out_data;
        repeat (10) begin
          @(negedge clk);
          n_vec++;
          if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== held) begin
            n_fail++;
            $display("FAIL bp_stall: in_ready=%b out_valid=%b data=%h want 0/1/%h", in_ready, out_valid, out_data, held);
          end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    idle(8);
    n_vec++;
    if (got.size() != exp_q.size()) begin
      n_fail++; $display("FAIL bp_count: got %0d words want %0d", got.size(), exp_q.size());
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (got[i].d !== exp_q[i].d || got[i].c !== exp_q[i].c) begin
        n_fail++; $display("FAIL bp_word%0d: got %h/%0d want %h/%0d", i, got[i].d, got[i].c, exp_q[i].d, exp_q[i].c);
      end
    end
  endtask

  task automatic test_random_neurons();
    logic done = 1'b0;
    got.delete(); exp_q.delete();
    fork
      begin
        for (int nrn = 0; nrn < 16; nrn++) begin
          int beats = $urandom_range(1, 4);
          logic eop = (nrn == 15) || ($urandom_range(0, 3) == 0);
          for (int b = 0; b < beats; b++)
            send_beat(rnd64(), rnd64(), 1'(b == beats - 1), eop, 1'($urandom_range(0, 1)));
          if ($urandom_range(0, 2) == 0) idle(1);
        end
        idle(1);
        done = 1'b1;
      end
      begin
        while (!done) begin out_ready = 1'($urandom_range(0, 1)); @(posedge clk); #1; end
        out_ready = 1'b1;
      end
    join
    idle(10);
    n_vec += 2;
    if (got.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rand_count: got %0d words want %0d", got.size(), exp_q.size());
    end
    if (sat_flag !== m_sat) begin n_fail++; $display("FAIL rand_sat: got %b want %b", sat_flag, m_sat); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (got[i].d !== exp_q[i].d || got[i].c !== exp_q[i].c) begin
        n_fail++; $display("FAIL rand_word%0d: got %h/%0d want %h/%0d", i, got[i].d, got[i].c, exp_q[i].d, exp_q[i].c);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] f, w;
    send_beat(rnd64(), rnd64(), 1'b1, 1'b0, 1'b0);
    send_beat(rnd64(), rnd64(), 1'b0, 1'b0, 1'b0);
    send_beat(rnd64(), rnd64(), 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    model_reset();
    f = rnd64(); w = rnd64();
    send_beat(f, w, 1'b1, 1'b1, 1'b0);
    idle(6);
    n_vec += 2;
    if (got.size() != 1 || exp_q.size() != 1) begin
      n_fail++; $display("FAIL rmid_count: got %0d words want 1", got.size());
    end else if (got[0].d !== exp_q[0].d || got[0].c !== 3'd1) begin
      n_fail++; $display("FAIL rmid_word: got %h/%0d want %h/1", got[0].d, got[0].c, exp_q[0].d);
    end
    if (sat_flag !== m_sat) begin n_fail++; $display("FAIL rmid_sat: got %b want %b", sat_flag, m_sat); end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_relu();
    test_saturation();
    test_backpressure();
    test_random_neurons();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
